// File: rtl/raybox_pkg.sv
// Shared raybox types: wall IDs, 6-bit BBGGRR colour constants and the
// saturating per-channel dim helper.
package raybox_pkg;

    localparam logic [1:0] WALL_RED   = 2'd0;
    localparam logic [1:0] WALL_XOR   = 2'd1;
    localparam logic [1:0] WALL_BRICK = 2'd2;
    localparam logic [1:0] WALL_PANEL = 2'd3;

    localparam logic [5:0] COL_BLACK     = 6'b00_00_00;
    localparam logic [5:0] COL_RED_LT    = 6'b00_00_11;
    localparam logic [5:0] COL_RED_DK    = 6'b00_00_10;
    localparam logic [5:0] COL_GREY_LT   = 6'b10_10_10;
    localparam logic [5:0] COL_GREY_DK   = 6'b01_01_01;
    localparam logic [5:0] COL_SHEEN_LT  = 6'b11_01_00;
    localparam logic [5:0] COL_SHEEN_DK  = 6'b11_00_00;
    localparam logic [5:0] COL_SHADE_LT  = 6'b01_00_00;
    localparam logic [5:0] COL_BRICK_LT  = 6'b11_00_00;
    localparam logic [5:0] COL_BRICK_DK  = 6'b10_00_00;
    localparam logic [5:0] COL_BEVHI_LT  = 6'b11_01_11;
    localparam logic [5:0] COL_BEVHI_DK  = 6'b10_00_10;
    localparam logic [5:0] COL_BEVLO_LT  = 6'b10_00_10;
    localparam logic [5:0] COL_BEVLO_DK  = 6'b01_00_01;
    localparam logic [5:0] COL_PANEL_LT  = 6'b10_00_11;
    localparam logic [5:0] COL_PANEL_DK  = 6'b01_00_10;

    function automatic logic [5:0] rgb_dim(input logic [5:0] rgb, input logic [1:0] dim);
        logic [5:0] r;
        r = '0;
        for (int c = 0; c < 3; c++)
            r[c*2 +: 2] = (rgb[c*2 +: 2] > dim) ? rgb[c*2 +: 2] - dim : 2'd0;
        return r;
    endfunction

endpackage

// File: rtl/row_render_pipe_if.sv
// Column-parameter, pixel and result signals between the tracer and the row pipe.
interface row_render_pipe_if #(
    parameter int TEX_BITS  = 6,
    parameter int SIZE_BITS = 11
);
    logic                 load;
    logic [1:0]           wall;
    logic                 side;
    logic [SIZE_BITS-1:0] size;
    logic [TEX_BITS-1:0]  texu;
    logic                 vinf;
    logic [TEX_BITS-1:0]  leak;
    logic [1:0]           dim;
    logic                 in_valid;
    logic [9:0]           hpos;
    logic [TEX_BITS-1:0]  texv;
    logic                 out_valid;
    logic                 hit;
    logic [5:0]           rgb;

    modport master (output load, wall, side, size, texu, vinf, leak, dim, in_valid, hpos, texv,
                    input  out_valid, hit, rgb);
    modport slave  (input  load, wall, side, size, texu, vinf, leak, dim, in_valid, hpos, texv,
                    output out_valid, hit, rgb);
endinterface

// File: rtl/wall_tex.sv
// Procedural wall textures: maps (wall, side, u, v) low bits to an undimmed colour.
module wall_tex
    import raybox_pkg::*;
(
    input  logic [1:0] wall,
    input  logic       side,
    input  logic [4:0] u,
    input  logic [4:0] v,
    output logic [5:0] rgb
);
    logic mortar, bev_hi, bev_lo;

    always_comb begin
        mortar = ((u == 5'd6) && !v[3]) || ((u == 5'd24) && v[3]);
        bev_hi = (u[3:1] == 3'd0) || (v[3:1] == 3'd7);
        bev_lo = (u[3:1] == 3'd7) || (v[3:1] == 3'd0);
        rgb    = COL_BLACK;
        unique case (wall)
            WALL_RED:   rgb = side ? COL_RED_LT : COL_RED_DK;
            WALL_XOR:   rgb = {u[0], side, u[2], side, u[4], side} ^ {v[0], 1'b0, v[2], 1'b0, v[4], 1'b0};
            WALL_BRICK: begin
                if (mortar)                rgb = side ? COL_GREY_LT : COL_GREY_DK;
                else if (v[2:0] == 3'd0)   rgb = side ? (u[0] ? COL_GREY_DK : COL_GREY_LT)
                                                      : (u[0] ? COL_BLACK   : COL_GREY_DK);
                else if (v[2:0] == 3'd7)   rgb = side ? COL_SHEEN_LT : COL_SHEEN_DK;
                else if (v[2:0] == 3'd1)   rgb = side ? COL_SHADE_LT : COL_BLACK;
                else                       rgb = side ? COL_BRICK_LT : COL_BRICK_DK;
            end
            default: begin
                if (bev_hi)      rgb = side ? COL_BEVHI_LT : COL_BEVHI_DK;
                else if (bev_lo) rgb = side ? COL_BEVLO_LT : COL_BEVLO_DK;
                else             rgb = side ? COL_PANEL_LT : COL_PANEL_DK;
            end
        endcase
    end
endmodule

// File: rtl/row_render_pipe.sv
// Two-stage per-pixel wall renderer: stage 1 hit test + texture from latched
// column parameters, stage 2 distance dim and hit mask.
module row_render_pipe
    import raybox_pkg::*;
#(
    parameter int H_VIEW    = 640,
    parameter int TEX_BITS  = 6,
    parameter int SIZE_BITS = 11
) (
    input  logic        clk,
    input  logic        reset,
    row_render_pipe_if.slave px
);
    localparam int STAGES = 2;
    localparam int HALF   = H_VIEW / 2;
    localparam logic [SIZE_BITS:0] HALF_W = (SIZE_BITS+1)'(HALF);

    logic [1:0]           wall_q, wall_d, dim_q, dim_d;
    logic                 side_q, side_d, vinf_q, vinf_d, full_q, full_d;
    logic [4:0]           texu_q, texu_d;
    logic [TEX_BITS-1:0]  leak_q, leak_d;
    logic [SIZE_BITS:0]   span_lo_q, span_lo_d, span_hi_q, span_hi_d, size_ext;
    logic [STAGES:1]      vld_pipe_q, vld_pipe_d;
    logic                 hit1_q, hit1_d, hit2_q, hit2_d;
    logic [5:0]           rgb1_q, rgb1_d, rgb2_q, rgb2_d, tex_rgb;
    logic [1:0]           dim1_q, dim1_d;
    logic                 in_span;

    wall_tex u_tex (
        .wall (wall_q),
        .side (side_q),
        .u    (texu_q),
        .v    (px.texv[4:0]),
        .rgb  (tex_rgb)
    );

    always_comb begin
        size_ext  = {1'b0, px.size};
        wall_d    = wall_q;
        side_d    = side_q;
        texu_d    = texu_q;
        vinf_d    = vinf_q;
        leak_d    = leak_q;
        dim_d     = dim_q;
        span_lo_d = span_lo_q;
        span_hi_d = span_hi_q;
        full_d    = full_q;
        if (px.load) begin
            wall_d    = px.wall;
            side_d    = px.side;
            texu_d    = px.texu[4:0];
            vinf_d    = px.vinf;
            leak_d    = px.leak;
            dim_d     = px.dim;
            span_lo_d = (size_ext >= HALF_W) ? '0 : HALF_W - size_ext;
            span_hi_d = HALF_W + size_ext;
            full_d    = (size_ext > HALF_W);
        end

        // Pixels in the load cycle see the old parameter registers.
        in_span    = (32'(span_lo_q) <= 32'(px.hpos)) && (32'(px.hpos) <= 32'(span_hi_q));
        hit1_d     = px.in_valid && (px.texv >= leak_q) &&
                     (vinf_q || (((32'(px.hpos) < 32'(HALF)) || (px.texv != '0)) && (full_q || in_span)));
        rgb1_d     = tex_rgb;
        dim1_d     = dim_q;
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], px.in_valid};

        hit2_d = vld_pipe_q[1] && hit1_q;
        rgb2_d = hit2_d ? rgb_dim(rgb1_q, dim1_q) : COL_BLACK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wall_q     <= WALL_RED;
            side_q     <= 1'b0;
            texu_q     <= '0;
            vinf_q     <= 1'b0;
            leak_q     <= '0;
            dim_q      <= '0;
            span_lo_q  <= HALF_W;
            span_hi_q  <= HALF_W;
            full_q     <= 1'b0;
            vld_pipe_q <= '0;
            hit1_q     <= 1'b0;
            rgb1_q     <= '0;
            dim1_q     <= '0;
            hit2_q     <= 1'b0;
            rgb2_q     <= '0;
        end else begin
            wall_q     <= wall_d;
            side_q     <= side_d;
            texu_q     <= texu_d;
            vinf_q     <= vinf_d;
            leak_q     <= leak_d;
            dim_q      <= dim_d;
            span_lo_q  <= span_lo_d;
            span_hi_q  <= span_hi_d;
            full_q     <= full_d;
            vld_pipe_q <= vld_pipe_d;
            hit1_q     <= hit1_d;
            rgb1_q     <= rgb1_d;
            dim1_q     <= dim1_d;
            hit2_q     <= hit2_d;
            rgb2_q     <= rgb2_d;
        end
    end

    assign px.out_valid = vld_pipe_q[STAGES];
    assign px.hit       = hit2_q;
    assign px.rgb       = rgb2_q;
endmodule

// File: tb/tb_row_render_pipe.sv
// Directed bench for row_render_pipe at H_VIEW=640: span edges, overflow, leak,
// textures/dim, load collision and mid-stream reset.
module tb_row_render_pipe;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    row_render_pipe_if #(.TEX_BITS(6), .SIZE_BITS(11)) bus ();

    row_render_pipe #(.H_VIEW(640), .TEX_BITS(6), .SIZE_BITS(11)) dut (
        .clk   (clk),
        .reset (reset),
        .px    (bus.slave)
    );

    task automatic do_load(input logic [1:0] wall, input logic side, input logic [10:0] size,
                           input logic [5:0] texu, input logic vinf, input logic [5:0] leak,
                           input logic [1:0] dim);
        @(negedge clk);
        bus.wall = wall; bus.side = side; bus.size = size; bus.texu = texu;
        bus.vinf = vinf; bus.leak = leak; bus.dim = dim; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Drives one pixel at the current negedge and returns the outputs two edges later.
    task automatic send_pix(input logic [9:0] hpos, input logic [5:0] texv,
                            output logic ov, output logic h, output logic [5:0] c);
        bus.hpos = hpos; bus.texv = texv; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        ov = bus.out_valid; h = bus.hit; c = bus.rgb;
    endtask

    task automatic test_reset();
        logic ov, h; logic [5:0] c;
        reset = 1'b1;
        bus.load = 1'b1; bus.wall = 2'd3; bus.side = 1'b1; bus.size = 11'd400;
        bus.texu = 6'd0; bus.vinf = 1'b1; bus.leak = 6'd0; bus.dim = 2'd0;
        bus.in_valid = 1'b1; bus.hpos = 10'd100; bus.texv = 6'd5;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_ov got=%b exp=0", bus.out_valid); end
        checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%b exp=0", bus.hit); end
        checks++; if (bus.rgb !== 6'd0) begin failures++; $display("FAIL rst_rgb got=%b exp=0", bus.rgb); end
        bus.load = 1'b0; bus.in_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_ov got=%b exp=0", bus.out_valid); end
        // Default parameters: span 320..320, wall red dark.
        send_pix(10'd320, 6'd1, ov, h, c);
        checks++; if ({ov, h, c} !== {1'b1, 1'b1, 6'b000010}) begin failures++; $display("FAIL rst_default_hit got=%b/%b/%b exp=1/1/000010", ov, h, c); end
        send_pix(10'd319, 6'd1, ov, h, c);
        checks++; if ({ov, h, c} !== {1'b1, 1'b0, 6'b000000}) begin failures++; $display("FAIL rst_default_miss got=%b/%b/%b exp=1/0/000000", ov, h, c); end
    endtask

    task automatic test_span_edges();
        logic ov, h; logic [5:0] c;
        logic [9:0] hp [4] = '{10'd219, 10'd220, 10'd420, 10'd421};
        logic       eh [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_load(2'd0, 1'b1, 11'd100, 6'd0, 1'b0, 6'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            send_pix(hp[i], 6'd5, ov, h, c);
            checks++; if (ov !== 1'b1) begin failures++; $display("FAIL span_ov hpos=%0d got=%b exp=1", hp[i], ov); end
            checks++; if (h !== eh[i]) begin failures++; $display("FAIL span_hit hpos=%0d got=%b exp=%b", hp[i], h, eh[i]); end
            checks++; if (c !== (eh[i] ? 6'b000011 : 6'b000000)) begin failures++; $display("FAIL span_rgb hpos=%0d got=%b", hp[i], c); end
        end
    endtask

    task automatic test_full_overflow();
        logic ov, h; logic [5:0] c;
        do_load(2'd0, 1'b1, 11'd400, 6'd0, 1'b0, 6'd0, 2'd0);
        send_pix(10'd0, 6'd5, ov, h, c);
        checks++; if ({h, c} !== {1'b1, 6'b000011}) begin failures++; $display("FAIL full_h0 got=%b/%b exp=1/000011", h, c); end
        send_pix(10'd639, 6'd5, ov, h, c);
        checks++; if ({h, c} !== {1'b1, 6'b000011}) begin failures++; $display("FAIL full_h639 got=%b/%b exp=1/000011", h, c); end
        send_pix(10'd319, 6'd0, ov, h, c);
        checks++; if (h !== 1'b1) begin failures++; $display("FAIL full_v0_h319 got=%b exp=1", h); end
        send_pix(10'd320, 6'd0, ov, h, c);
        checks++; if ({h, c} !== {1'b0, 6'b000000}) begin failures++; $display("FAIL full_v0_h320 got=%b/%b exp=0/000000", h, c); end
        do_load(2'd0, 1'b1, 11'd400, 6'd0, 1'b1, 6'd0, 2'd0);
        send_pix(10'd320, 6'd0, ov, h, c);
        checks++; if (h !== 1'b1) begin failures++; $display("FAIL vinf_h320 got=%b exp=1", h); end
        // size == HALF: span 0..640 without full.
        do_load(2'd0, 1'b1, 11'd320, 6'd0, 1'b0, 6'd0, 2'd0);
        send_pix(10'd0, 6'd5, ov, h, c);
        checks++; if (h !== 1'b1) begin failures++; $display("FAIL half_h0 got=%b exp=1", h); end
        send_pix(10'd639, 6'd5, ov, h, c);
        checks++; if (h !== 1'b1) begin failures++; $display("FAIL half_h639 got=%b exp=1", h); end
        send_pix(10'd400, 6'd0, ov, h, c);
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL half_v0_h400 got=%b exp=0", h); end
    endtask

    task automatic test_leak();
        logic ov, h; logic [5:0] c;
        do_load(2'd0, 1'b1, 11'd400, 6'd0, 1'b0, 6'd10, 2'd0);
        send_pix(10'd100, 6'd9, ov, h, c);
        checks++; if ({h, c} !== {1'b0, 6'b000000}) begin failures++; $display("FAIL leak_v9 got=%b/%b exp=0/000000", h, c); end
        send_pix(10'd100, 6'd10, ov, h, c);
        checks++; if ({h, c} !== {1'b1, 6'b000011}) begin failures++; $display("FAIL leak_v10 got=%b/%b exp=1/000011", h, c); end
    endtask

    task automatic test_tex_dim();
        logic ov, h; logic [5:0] c;
        do_load(2'd2, 1'b1, 11'd400, 6'd6, 1'b0, 6'd0, 2'd0);
        send_pix(10'd100, 6'd0, ov, h, c);
        checks++; if ({h, c} !== {1'b1, 6'b101010}) begin failures++; $display("FAIL brick_mortar got=%b/%b exp=1/101010", h, c); end
        do_load(2'd2, 1'b1, 11'd400, 6'd6, 1'b0, 6'd0, 2'd1);
        send_pix(10'd100, 6'd0, ov, h, c);
        checks++; if (c !== 6'b010101) begin failures++; $display("FAIL brick_dim1 got=%b exp=010101", c); end
        do_load(2'd2, 1'b1, 11'd400, 6'd1, 1'b0, 6'd0, 2'd0);
        send_pix(10'd100, 6'd8, ov, h, c);
        checks++; if (c !== 6'b010101) begin failures++; $display("FAIL brick_shadow got=%b exp=010101", c); end
        do_load(2'd3, 1'b0, 11'd400, 6'd4, 1'b0, 6'd0, 2'd0);
        send_pix(10'd100, 6'd4, ov, h, c);
        checks++; if (c !== 6'b010010) begin failures++; $display("FAIL panel_dark got=%b exp=010010", c); end
        do_load(2'd3, 1'b1, 11'd400, 6'd0, 1'b0, 6'd0, 2'd2);
        send_pix(10'd100, 6'd4, ov, h, c);
        checks++; if (c !== 6'b010001) begin failures++; $display("FAIL panel_bevel_dim2 got=%b exp=010001", c); end
        do_load(2'd1, 1'b0, 11'd400, 6'd5, 1'b0, 6'd0, 2'd0);
        send_pix(10'd100, 6'd1, ov, h, c);
        checks++; if (c !== 6'b001000) begin failures++; $display("FAIL xor got=%b exp=001000", c); end
        do_load(2'd0, 1'b1, 11'd400, 6'd0, 1'b0, 6'd0, 2'd3);
        send_pix(10'd100, 6'd5, ov, h, c);
        checks++; if ({h, c} !== {1'b1, 6'b000000}) begin failures++; $display("FAIL dim3_black got=%b/%b exp=1/000000", h, c); end
    endtask

    task automatic test_load_collision();
        do_load(2'd0, 1'b1, 11'd400, 6'd0, 1'b0, 6'd0, 2'd0);
        // B loads in the same cycle as pixel P.
        bus.wall = 2'd3; bus.side = 1'b0; bus.size = 11'd400; bus.texu = 6'd4;
        bus.vinf = 1'b0; bus.leak = 6'd0; bus.dim = 2'd0; bus.load = 1'b1;
        bus.hpos = 10'd100; bus.texv = 6'd4; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.hit, bus.rgb} !== {1'b1, 1'b1, 6'b000011})
            begin failures++; $display("FAIL collide_P got=%b/%b/%b exp=1/1/000011", bus.out_valid, bus.hit, bus.rgb); end
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.hit, bus.rgb} !== {1'b1, 1'b1, 6'b010010})
            begin failures++; $display("FAIL collide_Q got=%b/%b/%b exp=1/1/010010", bus.out_valid, bus.hit, bus.rgb); end
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.hit, bus.rgb} !== 8'd0)
            begin failures++; $display("FAIL collide_idle got=%b/%b/%b exp=0/0/000000", bus.out_valid, bus.hit, bus.rgb); end
    endtask

    task automatic test_reset_mid();
        logic ov, h; logic [5:0] c;
        do_load(2'd0, 1'b1, 11'd400, 6'd0, 1'b0, 6'd0, 2'd0);
        bus.hpos = 10'd100; bus.texv = 6'd5; bus.in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({bus.out_valid, bus.hit, bus.rgb} !== 8'd0)
                begin failures++; $display("FAIL midrst_cyc%0d got=%b/%b/%b exp=0/0/000000", i, bus.out_valid, bus.hit, bus.rgb); end
            @(negedge clk);
        end
        do_load(2'd0, 1'b0, 11'd0, 6'd0, 1'b0, 6'd0, 2'd0);
        send_pix(10'd320, 6'd1, ov, h, c);
        checks++; if ({ov, h, c} !== {1'b1, 1'b1, 6'b000010}) begin failures++; $display("FAIL size0_h320 got=%b/%b/%b exp=1/1/000010", ov, h, c); end
        send_pix(10'd320, 6'd0, ov, h, c);
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL size0_v0 got=%b exp=0", h); end
        send_pix(10'd321, 6'd1, ov, h, c);
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL size0_h321 got=%b exp=0", h); end
    endtask

    initial begin
        bus.load = 1'b0; bus.in_valid = 1'b0; bus.hpos = '0; bus.texv = '0;
        bus.wall = '0; bus.side = 1'b0; bus.size = '0; bus.texu = '0;
        bus.vinf = 1'b0; bus.leak = '0; bus.dim = '0;
        test_reset();
        test_span_edges();
        test_full_overflow();
        test_leak();
        test_tex_dim();
        test_load_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
